serial_word_shifter: RTL and testbench
======================================

Name: serial_word_shifter

Overview:
- Upstream feeder for the serial pattern-detector FSM: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `w`, which drives the detector's serial input directly.
- A one-word holding register plus the shift register give gap-free back-to-back streaming.
- The inter-word gap and bit order are configurable.
- Output `w` rests at a fixed idle level when no word is shifting.

Parameters:
- WIDTH, 8, bits per word; legal 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on `w` when not shifting (0 walks the detector back to s0).
- GAP_CYCLES, 0, idle cycles inserted between consecutive words; legal 0..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in valid.
- data_ready  output  1  holding register can accept a word.
- w  output  1  serial bit stream to the detector.
- w_valid  output  1  high while `w` carries a data bit.
- word_done  output  1  high during the cycle `w` carries a word's last bit.
- busy  output  1  state != IDLE or holding register full.

Behaviour:
- Reset: synchronous, active-high. Cleared state:
  - state=IDLE, hold_full=0, shift register=0, bit_cnt=0, gap_cnt=0.
  - Outputs: w=IDLE_LEVEL, w_valid=0, word_done=0, busy=0, data_ready=1.
- Reset mid-word: the word in flight and the held word are discarded. No partial bits are emitted after the reset edge.
- Handshake:
  - Transfer occurs on an edge where data_valid && data_ready.
  - data_ready = !hold_full (combinational from a register).
  - data_in is captured into the holding register, and hold_full sets.
  - data_valid while not ready has no effect; the source holds data_in.
- States: IDLE, SHIFT, GAP.
  - IDLE: w=IDLE_LEVEL, w_valid=0. If hold_full, next edge: shift reg<=hold, hold_full<=0, bit_cnt<=0, ->SHIFT.
  - SHIFT: w = current output bit (MSB or LSB of shift reg per MSB_FIRST), w_valid=1. Each edge shifts by one and increments bit_cnt.
  - SHIFT, last bit (bit_cnt==WIDTH-1): word_done=1 this cycle. On the next edge:
    - if GAP_CYCLES>0: ->GAP, gap_cnt<=0;
    - else if hold_full: reload from hold, stay in SHIFT (no bubble);
    - else: ->IDLE.
  - GAP: w=IDLE_LEVEL, w_valid=0, gap_cnt increments. When gap_cnt==GAP_CYCLES-1: if hold_full, reload and ->SHIFT; else ->IDLE.
- Latency: word accepted at edge E0 with shifter idle -> first bit on `w` in the cycle after edge E1; last bit in the cycle after E(WIDTH).
- Throughput: with GAP_CYCLES=0, continuous words give a continuous bit stream, one bit per clock.
- Simultaneous accept and reload: on the same edge that hold moves into the shifter, a new data_valid is NOT accepted (data_ready was 0); it is accepted on the following edge. This is still in time for gap-free streaming because WIDTH>=2.
- `w` is driven from registered state only (no combinational path from data_in/data_valid).
- Counter widths: bit_cnt is ceil(log2(WIDTH)) bits, gap_cnt is 4 bits; neither wraps past its terminal value.

Test Plan:
- Reset then idle 5 cycles -> w=0, w_valid=0, word_done=0, busy=0, data_ready=1 throughout.
- MSB_FIRST=1, send 8'hA0 at edge E0 -> w = 1,0,1,0,0,0,0,0 in cycles after E1..E8; word_done only in cycle after E8; downstream detector z=1 in cycle after E5; then w returns to 0, busy=0.
- Back-to-back 8'hAA, 8'h55, GAP_CYCLES=0 -> 16 contiguous w_valid cycles, bits 10101010 01010101; data_ready low only during hold-full cycles; exactly two word_done pulses.
- GAP_CYCLES=3, two words 8'hFF, 8'h81 -> 8 ones, then exactly 3 cycles w=0/w_valid=0, then 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, send 8'h05 -> w sequence 1,0,1,0,0,0,0,0.
- Assert reset during bit 4 of 8'hFF with a second word held -> next cycle w=0, w_valid=0, busy=0, data_ready=1; the held word is never emitted.

Source files
------------

// File: rtl/serial_word_shifter.sv
// serial_word_shifter: parallel words in over valid/ready, one bit per
// clock out on w, with a one-word holding register and optional gap.
module serial_word_shifter #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_sh;
  logic             r_hold_full;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_gap_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_gap_end;
  logic             w_bit;
  logic [WIDTH-1:0] w_sh_next;

  assign w_accept  = data_valid && !r_hold_full;
  assign w_last    = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);
  assign w_gap_end = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
  assign w_bit     = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
  assign w_sh_next = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0}
                               : {1'b0, r_sh[WIDTH-1:1]};

  // Accept and reload are exclusive: reload needs hold full, accept empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sh        <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            r_sh        <= r_hold;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh      <= w_sh_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last) begin
            r_bit_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= '0;
              r_state   <= GAP;
            end else if (r_hold_full) begin
              r_sh        <= r_hold;
              r_hold_full <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt + 4'd1;
          if (w_gap_end) begin
            r_gap_cnt <= '0;
            if (r_hold_full) begin
              r_sh        <= r_hold;
              r_hold_full <= 1'b0;
              r_bit_cnt   <= '0;
              r_state     <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_ready = !r_hold_full;
  assign w          = (r_state == SHIFT) ? w_bit : IDLE_LEVEL;
  assign w_valid    = (r_state == SHIFT);
  assign word_done  = w_last;
  assign busy       = (r_state != IDLE) || r_hold_full;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: directed steps plus random traffic
// checked against per-instance queues of expected serial bits.
module tb_serial_word_shifter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d0 = '0;
  logic [7:0] d1 = '0;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic       rdy0, w0, wv0, wd0, busy0;
  logic       rdy1, w1, wv1, wd1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic       acc0 = 1'b0;
  logic       acc1 = 1'b0;

  int run0 = 0;
  int run0_max = 0;
  int wd0_cnt = 0;
  int wd1_cnt = 0;
  int idle1 = 0;
  int gap1_last = -1;
  bit had1 = 1'b0;
  bit prev1 = 1'b0;

  always #5 clk = ~clk;

  serial_word_shifter #(
    .WIDTH(8), .MSB_FIRST(1'b1),
    .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)
  ) u0 (
    .clk(clk), .reset(reset),
    .data_in(d0), .data_valid(v0),
    .data_ready(rdy0), .w(w0),
    .w_valid(wv0), .word_done(wd0),
    .busy(busy0)
  );

  serial_word_shifter #(
    .WIDTH(8), .MSB_FIRST(1'b0),
    .IDLE_LEVEL(1'b0), .GAP_CYCLES(3)
  ) u1 (
    .clk(clk), .reset(reset),
    .data_in(d1), .data_valid(v1),
    .data_ready(rdy1), .w(w1),
    .w_valid(wv1), .word_done(wd1),
    .busy(busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Accepted words expand into {bit, is_last} entries in send order.
  always @(posedge clk) begin
    acc0 <= !reset && v0 && rdy0;
    acc1 <= !reset && v1 && rdy1;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (v0 && rdy0)
        for (int i = 0; i < 8; i++)
          q0.push_back({d0[7-i], i == 7});
      if (v1 && rdy1)
        for (int i = 0; i < 8; i++)
          q1.push_back({d1[i], i == 7});
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (reset) begin
      run0  = 0;
      idle1 = 0;
      had1  = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (wv0) begin
        e = (q0.size() > 0) ? q0.pop_front() : 2'bxx;
        chk("u0_bit", {w0, wd0}, e);
        run0++;
        if (run0 > run0_max) run0_max = run0;
        if (wd0) wd0_cnt++;
      end else begin
        chk("u0_idle", {w0, wd0}, 2'b00);
        run0 = 0;
      end
      if (wv1) begin
        if (!prev1 && had1) begin
          gap1_last = idle1;
          chk("u1_gap_min", 32'(idle1 >= 3), 1);
        end
        e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
        chk("u1_bit", {w1, wd1}, e);
        if (wd1) begin
          wd1_cnt++;
          had1 = 1'b1;
        end
        idle1 = 0;
      end else begin
        chk("u1_idle", {w1, wd1}, 2'b00);
        idle1++;
      end
      prev1 = wv1;
    end
  end

  task automatic send0(input logic [7:0] d);
    int t = 0;
    tick();
    d0 = d;
    v0 = 1'b1;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!acc0 && t < 64);
    chk("send0_accept", 32'(acc0), 1);
  endtask

  task automatic send1(input logic [7:0] d);
    int t = 0;
    tick();
    d1 = d;
    v1 = 1'b1;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!acc1 && t < 64);
    chk("send1_accept", 32'(acc1), 1);
  endtask

  initial begin
    logic [7:0] p;
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_w", w0, 0);
      chk("rst_wv", wv0, 0);
      chk("rst_wd", wd0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_rdy", rdy0, 1);
      chk("rst_busy1", busy1, 0);
      chk("rst_rdy1", rdy1, 1);
    end

    p = 8'hA0;
    send0(p);
    tick();
    v0 = 1'b0;
    chk("lat_wv", wv0, 0);
    chk("lat_busy", busy0, 1);
    chk("lat_rdy", rdy0, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("a0_wv", wv0, 1);
      chk("a0_w", w0, p[7-k]);
      chk("a0_done", wd0, 32'(k == 7));
    end
    tick();
    chk("a0_end_wv", wv0, 0);
    chk("a0_end_w", w0, 0);
    chk("a0_end_busy", busy0, 0);

    run0_max = 0;
    wd0_cnt  = 0;
    send0(8'hAA);
    send0(8'h55);
    chk("b2b_rdy", rdy0, 0);
    tick();
    v0 = 1'b0;
    repeat (20) tick();
    chk("b2b_run", run0_max, 16);
    chk("b2b_done", wd0_cnt, 2);

    wd1_cnt   = 0;
    gap1_last = -1;
    send1(8'hFF);
    send1(8'h81);
    tick();
    v1 = 1'b0;
    repeat (30) tick();
    chk("gap_len", gap1_last, 3);
    chk("gap_done", wd1_cnt, 2);

    p = 8'b1010_0000;
    send1(8'h05);
    tick();
    v1 = 1'b0;
    chk("lsb_lat_wv", wv1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("lsb_wv", wv1, 1);
      chk("lsb_w", w1, p[7-k]);
    end
    tick();
    chk("lsb_end_wv", wv1, 0);
    repeat (5) tick();

    send0(8'hFF);
    send0(8'h3C);
    tick();
    v0 = 1'b0;
    repeat (3) tick();
    chk("mid_wv", wv0, 1);
    reset = 1'b1;
    tick();
    chk("mrst_w", w0, 0);
    chk("mrst_wv", wv0, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_rdy", rdy0, 1);
    reset = 1'b0;
    repeat (12) tick();
    chk("mrst_quiet_wv", wv0, 0);
    chk("mrst_quiet_busy", busy0, 0);

    for (int c = 0; c < 600; c++) begin
      tick();
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0);
        d0 = 8'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 3) != 0);
        d1 = 8'($urandom);
      end
    end
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (60) tick();
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("drain_busy0", busy0, 0);
    chk("drain_busy1", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
